// File: rtl/order_content_arbiter_pkg.sv
// Shared types and constants for the order-content RAM arbiter.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package order_content_arbiter_pkg;

  localparam int ORDER_ADDR_W = 12;
  localparam int ORDER_DATA_W = 217;

  typedef enum logic {
    ST_CLEAR = 1'b0,
    ST_ARB   = 1'b1
  } state_t;

  // Requester ids double as bit positions in the arbiter req/grant vectors.
  localparam logic REQ_RD = 1'b0;
  localparam logic REQ_WR = 1'b1;

  // Saturating increment for the statistics counters.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/order_content_arbiter_if.sv
// Requester handshakes plus RAM port bundle for the order-content arbiter.
// Latency: n/a (wires only).
// Backpressure: wr/rd requests wait on *_ready; read responses have none.
interface order_content_arbiter_if
  import order_content_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH = ORDER_ADDR_W,
  parameter int DATA_WIDTH = ORDER_DATA_W
) ();

  logic                  wr_valid;
  logic                  wr_ready;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;

  logic                  rd_valid;
  logic                  rd_ready;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_resp_valid;
  logic [DATA_WIDTH-1:0] rd_resp_data;

  logic [ADDR_WIDTH-1:0] ram_addr;
  logic [DATA_WIDTH-1:0] ram_din;
  logic                  ram_we;
  logic [DATA_WIDTH-1:0] ram_dout;

  // Arbiter side.
  modport slave (
    input  wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_dout,
    output wr_ready, rd_ready, rd_resp_valid, rd_resp_data,
           ram_addr, ram_din, ram_we
  );

  // Requesters and RAM side.
  modport master (
    output wr_valid, wr_addr, wr_data, rd_valid, rd_addr, ram_dout,
    input  wr_ready, rd_ready, rd_resp_valid, rd_resp_data,
           ram_addr, ram_din, ram_we
  );

endinterface

// File: rtl/order_content_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; priority pointer flips only on contention.
// Latency: grant is combinational from req in the same cycle.
// Backpressure: a losing requester simply sees no grant and retries.
module rr_arb2
  import order_content_arbiter_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  output logic [1:0] grant
);

  logic ptr;

  // Hand priority to the other side after every contended grant.
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= REQ_RD;
    end else if (req == 2'b11) begin
      ptr <= ~ptr;
    end
  end

  // Single requester wins outright; on contention the pointer decides.
  always_comb begin
    grant = req;
    if (req == 2'b11) begin
      grant      = 2'b00;
      grant[ptr] = 1'b1;
    end
  end

endmodule

// File: rtl/order_content_arbiter.sv
// Shares the single-port order-content RAM between writer and reader; clears RAM after reset.
// Latency: read data 1 cycle after the read grant; one RAM access per cycle.
// Backpressure: wr_ready/rd_ready low during clear or when the other side wins. Optional stats: ORDER_CONTENT_ARB_STATS_EN.
module order_content_arbiter
  import order_content_arbiter_pkg::*;
#(
  parameter int ADDR_WIDTH     = ORDER_ADDR_W,
  parameter int DATA_WIDTH     = ORDER_DATA_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset,
  order_content_arbiter_if.slave   bus,
  output logic                     init_done
`ifdef ORDER_CONTENT_ARB_STATS_EN
  ,
  output logic [31:0]              stat_wr_cnt,
  output logic [31:0]              stat_rd_cnt,
  output logic [31:0]              stat_conflict_cnt
`endif
);

  localparam logic [ADDR_WIDTH-1:0] CLR_LAST = '1;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_cnt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  resp_q;
  logic                  in_arb;
  logic [1:0]            req, grant;
  logic                  grant_wr, grant_rd;

  logic                  wr_ready_c, rd_ready_c, ram_we_c;
  logic [ADDR_WIDTH-1:0] ram_addr_c;
  logic [DATA_WIDTH-1:0] ram_din_c;

  // Requests are only visible to the arbiter once clear is finished.
  assign in_arb       = (state == ST_ARB) && !reset;
  assign req[REQ_RD]  = in_arb && bus.rd_valid;
  assign req[REQ_WR]  = in_arb && bus.wr_valid;

  rr_arb2 u_arb (
    .clk   (clk),
    .reset (reset),
    .req   (req),
    .grant (grant)
  );

  assign grant_wr = grant[REQ_WR];
  assign grant_rd = grant[REQ_RD];

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= CLEAR_ON_RESET ? ST_CLEAR : ST_ARB;
    end else begin
      state <= state_nxt;
    end
  end

  // Leave CLEAR once the last address has been written.
  always_comb begin
    state_nxt = state;
    if ((state == ST_CLEAR) && (clr_cnt == CLR_LAST)) begin
      state_nxt = ST_ARB;
    end
  end

  // Clear counter, done flag, held address and read-response valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      clr_cnt   <= '0;
      init_done <= !CLEAR_ON_RESET;
      addr_q    <= '0;
      resp_q    <= 1'b0;
    end else begin
      resp_q <= grant_rd;
      if (state == ST_CLEAR) begin
        clr_cnt <= clr_cnt + 1'b1;
        addr_q  <= clr_cnt;
        if (clr_cnt == CLR_LAST) begin
          init_done <= 1'b1;
        end
      end else if (grant_wr || grant_rd) begin
        addr_q <= ram_addr_c;
      end
    end
  end

  // RAM port and ready outputs; idle cycles keep the last address on the bus.
  always_comb begin
    wr_ready_c = 1'b0;
    rd_ready_c = 1'b0;
    ram_we_c   = 1'b0;
    ram_addr_c = addr_q;
    ram_din_c  = bus.wr_data;
    if (reset) begin
      ram_addr_c = '0;
      ram_din_c  = '0;
    end else if (state == ST_CLEAR) begin
      ram_we_c   = 1'b1;
      ram_addr_c = clr_cnt;
      ram_din_c  = '0;
    end else begin
      wr_ready_c = grant_wr;
      rd_ready_c = grant_rd;
      ram_we_c   = grant_wr;
      if (grant_wr) begin
        ram_addr_c = bus.wr_addr;
      end else if (grant_rd) begin
        ram_addr_c = bus.rd_addr;
      end
    end
  end

  assign bus.wr_ready      = wr_ready_c;
  assign bus.rd_ready      = rd_ready_c;
  assign bus.ram_we        = ram_we_c;
  assign bus.ram_addr      = ram_addr_c;
  assign bus.ram_din       = ram_din_c;
  assign bus.rd_resp_valid = resp_q;
  assign bus.rd_resp_data  = bus.ram_dout;

`ifdef ORDER_CONTENT_ARB_STATS_EN
  // Saturating activity counters, frozen while clearing.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_wr_cnt       <= '0;
      stat_rd_cnt       <= '0;
      stat_conflict_cnt <= '0;
    end else if (in_arb) begin
      if (grant_wr) stat_wr_cnt <= sat_inc(stat_wr_cnt);
      if (grant_rd) stat_rd_cnt <= sat_inc(stat_rd_cnt);
      if (bus.wr_valid && bus.rd_valid) stat_conflict_cnt <= sat_inc(stat_conflict_cnt);
    end
  end
`endif

endmodule
